// File: rtl/conv_encoder_param_if.sv
// Stream bundle for the convolutional encoder: one-bit information input stream
// and two-bit coded symbol output stream, each with valid/ready/last.
interface conv_encoder_param_if;
  logic       in_bit;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] out_sym;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  // Environment side: produces information bits, consumes symbols.
  modport master (
    output in_bit, in_valid, in_last, out_ready,
    input  in_ready, out_sym, out_valid, out_last
  );

  // Encoder side: consumes information bits, produces symbols.
  modport slave (
    input  in_bit, in_valid, in_last, out_ready,
    output in_ready, out_sym, out_valid, out_last
  );
endinterface

// File: rtl/conv_encoder_param.sv
// Rate-1/2 feed-forward convolutional encoder with parametrised constraint length
// and generators. One registered symbol slot; optional K-1 zero-bit tail per frame
// so that every frame starts and ends in trellis state 0.
module conv_encoder_param #(
  parameter int unsigned     K       = 3,
  parameter logic [K-1:0]    G0      = 3'b111,
  parameter logic [K-1:0]    G1      = 3'b101,
  parameter bit              TAIL_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  conv_encoder_param_if.slave   bus,
  output logic                  busy
);

  localparam int unsigned SW = K - 1;
  localparam int unsigned TW = $clog2(K);

  // Elaboration-time legality checks.
  if (K < 3 || K > 9) begin : gen_bad_k
    $error("conv_encoder_param: K must be within 3..9");
  end
  if (!G0[K-1] || !G1[K-1]) begin : gen_bad_g
    $error("conv_encoder_param: generator MSBs must be 1");
  end

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [1:0]    sym_q, sym_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;

  logic          slot_free;
  logic          accept;
  logic          flush_step;
  logic          u;
  logic [K-1:0]  r;

  // Slot frees when empty or being drained this cycle; no path from in_valid.
  assign slot_free    = !valid_q || bus.out_ready;
  assign bus.in_ready = slot_free && (state_q != StFlush) && rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign flush_step   = (state_q == StFlush) && slot_free;
  // Tail bits are zero; u is only meaningful when a symbol is loaded.
  assign u            = accept & bus.in_bit;
  assign r            = {u, s_q};

  assign bus.out_sym   = sym_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign busy          = (state_q != StIdle) || valid_q;

  // Next-state: output slot, shift state, tail counter and frame FSM.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    tail_d  = tail_q;
    sym_d   = sym_q;
    valid_d = valid_q;
    last_d  = last_q;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (accept || flush_step) begin
      valid_d = 1'b1;
      sym_d   = {^(r & G0), ^(r & G1)};
      last_d  = 1'b0;
      s_d     = {u, s_q[SW-1:1]};
    end

    unique case (state_q)
      StIdle, StRun: begin
        if (accept) begin
          state_d = StRun;
          if (bus.in_last) begin
            if (TAIL_EN) begin
              state_d = StFlush;
            end else begin
              // Untailed frame: terminate by clearing the state directly.
              state_d = StIdle;
              last_d  = 1'b1;
              s_d     = '0;
            end
          end
        end
      end
      StFlush: begin
        if (flush_step) begin
          if (tail_q == TW'(K - 2)) begin
            last_d  = 1'b1;
            tail_d  = '0;
            state_d = StIdle;
          end else begin
            tail_d = tail_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      s_q     <= '0;
      tail_q  <= '0;
      sym_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      tail_q  <= tail_d;
      sym_q   <= sym_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/conv_encoder_param.md
Name: conv_encoder_param

Overview:
Parametrised rate-1/2 feed-forward convolutional encoder. Constraint length and both generator polynomials are set by parameters. Accepts one information bit per valid/ready handshake and emits one 2-bit coded symbol per handshake. Optionally appends K-1 zero tail bits per frame to terminate the trellis, so the downstream Viterbi decoder starts and ends each frame in state 0.

Parameters:
K, 3, constraint length; legal range 3..9; shift state is K-1 bits.
G0, 3'b111, K-bit generator for out_sym[1]; MSB taps the current input bit.
G1, 3'b101, K-bit generator for out_sym[0]; MSB taps the current input bit.
TAIL_EN, 1, 1 = append K-1 zero tail bits after in_last; 0 = no tail, state cleared at frame end.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-low.
in_bit  input  1  information bit.
in_valid  input  1  in_bit/in_last valid.
in_last  input  1  marks final information bit of a frame.
in_ready  output  1  encoder accepts in_bit this cycle.
out_sym  output  2  coded symbol {g0 parity, g1 parity}.
out_valid  output  1  out_sym valid.
out_last  output  1  final symbol of the frame (tail included when TAIL_EN=1).
out_ready  input  1  downstream accepts out_sym.
busy  output  1  high in RUN or FLUSH, or while out_valid=1.

Behaviour:
- Reset (rst=0 at rising edge): state s[K-2:0]=0, FSM=IDLE, out_valid=0, out_sym=0, out_last=0, tail counter=0. Reset overrides every other event, including mid-frame and mid-flush; the partially emitted frame is discarded.
- Encoding: r = {u, s[K-2:0]}, where u is the accepted bit (0 during tail).
  - out_sym[1] = XOR-reduce(r & G0); out_sym[0] = XOR-reduce(r & G1).
  - Per encoded bit, the state updates as s <= {u, s[K-2:1]}: s[K-2] is the newest bit, s[0] the oldest.
- Output stage: one registered symbol slot. A slot "frees" when out_valid=0, or when out_valid=1 and out_ready=1.
- Latency: the symbol for a bit accepted at edge N has out_valid=1 from edge N onward (one register stage). Full throughput is one symbol per clock when out_ready is held high.
- in_ready = slot frees this cycle AND FSM != FLUSH AND rst=1. Combinational from out_valid/out_ready/FSM; no combinational path from in_valid.
- Accept = in_valid & in_ready.
- out_valid/out_sym/out_last hold steady while out_valid=1 and out_ready=0. out_valid is never dropped without a handshake.
- FSM:
  - IDLE: on accept, go to RUN. If the accepted bit has in_last=1, go to FLUSH (TAIL_EN=1) or stay in IDLE (TAIL_EN=0).
  - RUN: each accept encodes a bit. An accept with in_last=1 goes to FLUSH if TAIL_EN=1. If TAIL_EN=0, it sets out_last on that symbol, clears s to 0 and returns to IDLE.
  - FLUSH: each cycle the slot frees, encode u=0 and increment the tail counter. The (K-1)th tail symbol carries out_last=1. After it, s=0 (inherent), the counter is cleared, and the FSM returns to IDLE.
- Frame length: N information bits produce N+K-1 symbols (TAIL_EN=1) or N symbols (TAIL_EN=0). A frame with N=1 is legal.
- Back-to-back frames: the first bit of the next frame may be accepted in the cycle the final tail symbol is taken. No bubble is required beyond the FLUSH handshakes.
- out_last is asserted only with out_valid=1 and clears on the next load of a non-final symbol.
- Tail counter width is clog2(K). No wrap occurs, since it is cleared on leaving FLUSH.
- G0/G1 MSB must be 1; this is checked by elaboration assertion.

Test Plan:
1. Defaults (K=3, 111/101, TAIL_EN=1), out_ready=1, frame 1,0,1,1 (in_last on 4th bit) -> out_sym 11,10,00,01,01,11; out_last only on 6th; in_ready=0 for exactly the 2 tail cycles.
2. K=7, G0=7'b1111001, G1=7'b1011011, single-bit frame in_bit=1, in_last=1 -> impulse response 11,10,11,11,00,01,11 (7 symbols), out_last on 7th, s=0 afterwards.
3. Test 1 stimulus with out_ready toggling 1,0,0,1 repeating -> identical symbol sequence; out_sym stable while stalled; no symbol lost or duplicated; in_ready low whenever the slot is full and not taken.
4. TAIL_EN=0, defaults, frames [1,1] then [1] back-to-back -> 11,01 (out_last on 2nd), then 11 (out_last) proving state cleared between frames.
5. Reset during FLUSH (rst=0 one cycle after the first tail symbol of test 1) -> next edge out_valid=0, busy=0, in_ready=1 after release; a new frame [1] encodes 11,10,11.
6. Random 1000-bit frames with random in_valid/out_ready, default and K=7 configs -> scoreboard against a reference model; symbol count N+K-1 per frame; out_last exactly once per frame.
